reu_reg_file: RTL and testbench

// CPU-side responder of the REU: decodes C64 accesses to $DF00-$DF1F and holds the command, address,

---
 rtl/reu_reg_file.sv | 149 ++++++++++++++
 tb/tb_reu_reg_file.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reu_reg_file.sv
// REU CPU-side register file: $DF00-$DF1F decode, transfer registers with shadows,
// trigger logic, address/length stepping driven by the DMA sequencer, status and IRQ.
module reu_reg_file #(
  parameter int REUA_BITS = 24,
  parameter bit SIZE_BIT  = 1'b1
) (
  input  logic        PHI2,
  input  logic        nRESET,
  input  logic        RegReset,
  input  logic        nIO2,
  input  logic        RnW,
  input  logic [15:0] A,
  input  logic [7:0]  Din,
  output logic [7:0]  Dout,
  output logic        DoutOE,
  input  logic        DMA,
  input  logic        NextCA,
  input  logic        NextREUA,
  input  logic        XferEnd,
  input  logic        VerifyErr,
  output logic        Execute,
  output logic [1:0]  XferType,
  output logic        Length1,
  output logic [15:0] CA,
  output logic [23:0] REUA,
  output logic        nIRQ
);
  localparam int BANK_BITS = REUA_BITS - 16;
  localparam logic [REUA_BITS-1:0] REUA_ONE = 1;

  logic                 r_cmd_exec, r_cmd_autoload, r_cmd_ff00dis;
  logic [1:0]           r_cmd_type;
  logic [15:0]          r_ca, r_ca_sh, r_len, r_len_sh;
  logic [REUA_BITS-1:0] r_reua, r_reua_sh;
  logic [2:0]           r_imr;
  logic [1:0]           r_acr;
  logic                 r_eob, r_fault, r_armed;

  logic                 w_wr, w_rd, w_ff00_trig, w_irq_pend;
  logic [7:0]           w_bank_rd;

  assign w_wr        = !nIO2 && !RnW && !DMA;
  assign w_rd        = !nIO2 && RnW && !DMA;
  assign w_ff00_trig = !RnW && !DMA && (A == 16'hFF00) && r_cmd_exec && !r_cmd_ff00dis;
  assign w_irq_pend  = r_imr[2] && ((r_imr[1] && r_eob) || (r_imr[0] && r_fault));

  assign DoutOE   = !nIO2 && RnW && !DMA;
  assign Execute  = r_armed && r_cmd_exec;
  assign XferType = r_cmd_type;
  assign Length1  = (r_len == 16'h0001);
  assign CA       = r_ca;
  assign REUA     = 24'(r_reua);
  assign nIRQ     = !w_irq_pend;

  // Unimplemented bank bits read back as 1
  for (genvar gi = 0; gi < 8; gi++) begin : g_bank
    if (gi < BANK_BITS) begin : g_impl
      assign w_bank_rd[gi] = r_reua[16+gi];
    end else begin : g_pad
      assign w_bank_rd[gi] = 1'b1;
    end
  end

  always_comb begin
    Dout = 8'hFF;
    case (A[4:0])
      5'h00: Dout = {w_irq_pend, r_eob, r_fault, SIZE_BIT, 4'b0000};
      5'h01: Dout = {r_cmd_exec, 1'b1, r_cmd_autoload, r_cmd_ff00dis, 2'b11, r_cmd_type};
      5'h02: Dout = r_ca[7:0];
      5'h03: Dout = r_ca[15:8];
      5'h04: Dout = r_reua[7:0];
      5'h05: Dout = r_reua[15:8];
      5'h06: Dout = w_bank_rd;
      5'h07: Dout = r_len[7:0];
      5'h08: Dout = r_len[15:8];
      5'h09: Dout = {r_imr, 5'b11111};
      5'h0A: Dout = {r_acr, 6'b111111};
      default: Dout = 8'hFF;
    endcase
  end

  always_ff @(negedge PHI2 or negedge nRESET) begin
    if (!nRESET) begin
      r_cmd_exec <= 1'b0; r_cmd_autoload <= 1'b0; r_cmd_ff00dis <= 1'b1; r_cmd_type <= 2'b00;
      r_ca <= '0; r_ca_sh <= '0; r_reua <= '0; r_reua_sh <= '0;
      r_len <= 16'hFFFF; r_len_sh <= 16'hFFFF;
      r_imr <= '0; r_acr <= '0; r_eob <= 1'b0; r_fault <= 1'b0; r_armed <= 1'b0;
    end else if (RegReset) begin
      r_cmd_exec <= 1'b0; r_cmd_autoload <= 1'b0; r_cmd_ff00dis <= 1'b1; r_cmd_type <= 2'b00;
      r_ca <= '0; r_ca_sh <= '0; r_reua <= '0; r_reua_sh <= '0;
      r_len <= 16'hFFFF; r_len_sh <= 16'hFFFF;
      r_imr <= '0; r_acr <= '0; r_eob <= 1'b0; r_fault <= 1'b0; r_armed <= 1'b0;
    end else begin
      if (w_wr) begin
        case (A[4:0])
          5'h01: begin
            r_cmd_exec     <= Din[7];
            r_cmd_autoload <= Din[5];
            r_cmd_ff00dis  <= Din[4];
            r_cmd_type     <= Din[1:0];
            r_armed        <= Din[7] && Din[4];
          end
          5'h02: begin r_ca[7:0]    <= Din; r_ca_sh[7:0]    <= Din; end
          5'h03: begin r_ca[15:8]   <= Din; r_ca_sh[15:8]   <= Din; end
          5'h04: begin r_reua[7:0]  <= Din; r_reua_sh[7:0]  <= Din; end
          5'h05: begin r_reua[15:8] <= Din; r_reua_sh[15:8] <= Din; end
          5'h06: begin
            r_reua[REUA_BITS-1:16]    <= Din[BANK_BITS-1:0];
            r_reua_sh[REUA_BITS-1:16] <= Din[BANK_BITS-1:0];
          end
          5'h07: begin r_len[7:0]  <= Din; r_len_sh[7:0]  <= Din; end
          5'h08: begin r_len[15:8] <= Din; r_len_sh[15:8] <= Din; end
          5'h09: r_imr <= Din[7:5];
          5'h0A: r_acr <= Din[7:6];
          default: ;
        endcase
      end
      if (w_rd && (A[4:0] == 5'h00)) begin
        r_eob   <= 1'b0;
        r_fault <= 1'b0;
      end
      if (w_ff00_trig)
        r_armed <= 1'b1;
      if (NextCA) begin
        if (!r_acr[1])
          r_ca <= r_ca + 16'd1;
        if (r_len != 16'h0001)
          r_len <= r_len - 16'd1;
      end
      if (NextREUA && !r_acr[0])
        r_reua <= r_reua + REUA_ONE;
      // End of block is last so its flags and autoload reload win over everything above
      if (XferEnd) begin
        r_cmd_exec    <= 1'b0;
        r_armed       <= 1'b0;
        r_cmd_ff00dis <= 1'b1;
        if (Length1)
          r_eob <= 1'b1;
        if (VerifyErr)
          r_fault <= 1'b1;
        if (r_cmd_autoload) begin
          r_ca   <= r_ca_sh;
          r_reua <= r_reua_sh;
          r_len  <= r_len_sh;
        end
      end
    end
  end
endmodule

// File: tb/tb_reu_reg_file.sv
// Self-checking bench for reu_reg_file: directed scenarios plus randomized CPU/sequencer
// traffic compared against an integer-level model of the register file.
module tb_reu_reg_file;
  localparam int RB = 19;

  logic        PHI2 = 1'b1, nRESET = 1'b0, RegReset = 1'b0, nIO2 = 1'b1, RnW = 1'b1;
  logic [15:0] A = 16'h0000;
  logic [7:0]  Din = 8'h00;
  logic        DMA = 1'b0, NextCA = 1'b0, NextREUA = 1'b0, XferEnd = 1'b0, VerifyErr = 1'b0;
  logic [7:0]  Dout;
  logic        DoutOE, Execute, Length1, nIRQ;
  logic [1:0]  XferType;
  logic [15:0] CA;
  logic [23:0] REUA;

  reu_reg_file #(.REUA_BITS(RB), .SIZE_BIT(1'b1)) dut (
    .PHI2(PHI2), .nRESET(nRESET), .RegReset(RegReset), .nIO2(nIO2), .RnW(RnW),
    .A(A), .Din(Din), .Dout(Dout), .DoutOE(DoutOE), .DMA(DMA),
    .NextCA(NextCA), .NextREUA(NextREUA), .XferEnd(XferEnd), .VerifyErr(VerifyErr),
    .Execute(Execute), .XferType(XferType), .Length1(Length1), .CA(CA), .REUA(REUA),
    .nIRQ(nIRQ)
  );

  always #5 PHI2 = ~PHI2;

  int checks = 0;
  int errors = 0;

  // Reference model state, plain integers
  int m_ca, m_reua, m_len, m_ca_sh, m_reua_sh, m_len_sh, m_cmd, m_imr, m_acr;
  bit m_eob, m_fault, m_armed;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int set_byte(input int x, input int sh, input int d);
    return (x & ~(255 << sh)) | ((d & 255) << sh);
  endfunction

  task automatic model_reset();
    m_ca = 0; m_reua = 0; m_len = 65535;
    m_ca_sh = 0; m_reua_sh = 0; m_len_sh = 65535;
    m_cmd = 'h10; m_imr = 0; m_acr = 0;
    m_eob = 0; m_fault = 0; m_armed = 0;
  endtask

  function automatic bit m_pending();
    return ((m_imr & 'h80) != 0) &&
           ((((m_imr & 'h40) != 0) && m_eob) || (((m_imr & 'h20) != 0) && m_fault));
  endfunction

  function automatic bit m_exec();
    return m_armed && ((m_cmd & 'h80) != 0);
  endfunction

  function automatic int m_read(input int r);
    int v;
    case (r)
      0:  v = (int'(m_pending()) << 7) | (int'(m_eob) << 6) | (int'(m_fault) << 5) | 'h10;
      1:  v = m_cmd | 'h4C;
      2:  v = m_ca;
      3:  v = m_ca >> 8;
      4:  v = m_reua;
      5:  v = m_reua >> 8;
      6:  v = (m_reua >> 16) | ('hFF << (RB - 16));
      7:  v = m_len;
      8:  v = m_len >> 8;
      9:  v = m_imr | 'h1F;
      10: v = m_acr | 'h3F;
      default: v = 'hFF;
    endcase
    return v & 255;
  endfunction

  // Apply one falling edge of PHI2 to the model using the currently driven inputs
  task automatic model_edge();
    bit l1;
    int r, d;
    if (RegReset) begin
      model_reset();
      return;
    end
    l1 = (m_len == 1);
    r = int'(A[4:0]);
    d = int'(Din);
    if (!DMA && !nIO2 && !RnW) begin
      case (r)
        1:  begin m_cmd = d; m_armed = ((d & 'h90) == 'h90); end
        2:  begin m_ca = set_byte(m_ca, 0, d);   m_ca_sh = set_byte(m_ca_sh, 0, d); end
        3:  begin m_ca = set_byte(m_ca, 8, d);   m_ca_sh = set_byte(m_ca_sh, 8, d); end
        4:  begin m_reua = set_byte(m_reua, 0, d); m_reua_sh = set_byte(m_reua_sh, 0, d); end
        5:  begin m_reua = set_byte(m_reua, 8, d); m_reua_sh = set_byte(m_reua_sh, 8, d); end
        6:  begin
              m_reua    = set_byte(m_reua, 16, d % (1 << (RB - 16)));
              m_reua_sh = set_byte(m_reua_sh, 16, d % (1 << (RB - 16)));
            end
        7:  begin m_len = set_byte(m_len, 0, d); m_len_sh = set_byte(m_len_sh, 0, d); end
        8:  begin m_len = set_byte(m_len, 8, d); m_len_sh = set_byte(m_len_sh, 8, d); end
        9:  m_imr = d;
        10: m_acr = d;
        default: ;
      endcase
    end
    if (!DMA && !nIO2 && RnW && r == 0) begin
      m_eob = 0;
      m_fault = 0;
    end
    if (!DMA && !RnW && A == 16'hFF00 && (m_cmd & 'h90) == 'h80)
      m_armed = 1;
    if (NextCA) begin
      if ((m_acr & 'h80) == 0) m_ca = (m_ca + 1) % 65536;
      if (m_len != 1) m_len = (m_len + 65535) % 65536;
    end
    if (NextREUA && (m_acr & 'h40) == 0)
      m_reua = (m_reua + 1) % (1 << RB);
    if (XferEnd) begin
      m_cmd = (m_cmd & ~'h80) | 'h10;
      m_armed = 0;
      if (l1) m_eob = 1;
      if (VerifyErr) m_fault = 1;
      if ((m_cmd & 'h20) != 0) begin
        m_ca = m_ca_sh; m_reua = m_reua_sh; m_len = m_len_sh;
      end
    end
  endtask

  task automatic check_outputs();
    chk("execute",  32'(Execute),  32'(m_exec()));
    chk("nirq",     32'(nIRQ),     32'(!m_pending()));
    chk("length1",  32'(Length1),  32'(m_len == 1));
    chk("ca",       32'(CA),       m_ca);
    chk("reua",     32'(REUA),     m_reua);
    chk("xfertype", 32'(XferType), m_cmd & 3);
  endtask

  task automatic idle();
    nIO2 = 1'b1; RnW = 1'b1; A = 16'h0000; Din = 8'h00; DMA = 1'b0;
    NextCA = 1'b0; NextREUA = 1'b0; XferEnd = 1'b0; VerifyErr = 1'b0; RegReset = 1'b0;
  endtask

  task automatic edge_step();
    @(negedge PHI2);
    model_edge();
    #1;
    check_outputs();
    idle();
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d, input logic dma);
    nIO2 = (a[15:8] != 8'hDF); RnW = 1'b0; A = a; Din = d; DMA = dma;
    $display("wr   A=%h D=%h dma=%0d", a, d, dma);
    edge_step();
  endtask

  task automatic cpu_read(input logic [15:0] a, input logic dma, output logic [7:0] d);
    int exp;
    nIO2 = 1'b0; RnW = 1'b1; A = a; DMA = dma;
    #1;
    exp = m_read(int'(a[4:0]));
    d = Dout;
    chk("dout_oe", 32'(DoutOE), 32'(!dma));
    if (!dma) chk("dout", 32'(Dout), exp);
    $display("rd   A=%h D=%h dma=%0d", a, Dout, dma);
    edge_step();
  endtask

  task automatic strobe(input logic nca, input logic nreua, input logic xend, input logic verr);
    DMA = 1'b1; NextCA = nca; NextREUA = nreua; XferEnd = xend; VerifyErr = verr;
    $display("seq  ca=%0d reua=%0d end=%0d verr=%0d", nca, nreua, xend, verr);
    edge_step();
  endtask

  logic [7:0] rd;
  logic [7:0] rst_tab [11] = '{8'h10, 8'h5C, 8'h00, 8'h00, 8'h00, 8'h00,
                               8'hF8, 8'hFF, 8'hFF, 8'h1F, 8'h3F};

  initial begin
    idle();
    model_reset();
    repeat (2) @(negedge PHI2);
    #2 nRESET = 1'b1;
    #1 check_outputs();

    // Reset values of every implemented register
    for (int i = 0; i < 11; i++) begin
      cpu_read(16'hDF00 + 16'(i), 1'b0, rd);
      chk("reset_reg", 32'(rd), 32'(rst_tab[i]));
    end

    // Immediate-trigger transfer with Length1 at end of block
    cpu_write(16'hDF02, 8'h00, 1'b0); cpu_write(16'hDF03, 8'h10, 1'b0);
    cpu_write(16'hDF04, 8'h00, 1'b0); cpu_write(16'hDF05, 8'h00, 1'b0);
    cpu_write(16'hDF06, 8'h02, 1'b0);
    cpu_write(16'hDF07, 8'h03, 1'b0); cpu_write(16'hDF08, 8'h00, 1'b0);
    cpu_write(16'hDF01, 8'h90, 1'b0);
    chk("s2_exec", 32'(Execute), 32'd1);
    repeat (3) strobe(1'b1, 1'b1, 1'b0, 1'b0);
    strobe(1'b0, 1'b0, 1'b1, 1'b0);
    chk("s2_ca", 32'(CA), 32'h1003);
    chk("s2_reua", 32'(REUA), 32'h020003);
    chk("s2_len1", 32'(Length1), 32'd1);
    chk("s2_exec_off", 32'(Execute), 32'd0);
    cpu_read(16'hDF01, 1'b0, rd); chk("s2_cmd", 32'(rd), 32'h5C);
    cpu_read(16'hDF00, 1'b0, rd); chk("s2_status", 32'(rd), 32'h50);

    // $FF00-deferred trigger
    cpu_write(16'hDF01, 8'h80, 1'b0); chk("s3_wait", 32'(Execute), 32'd0);
    cpu_write(16'hDF01, 8'h80, 1'b0); chk("s3_still", 32'(Execute), 32'd0);
    cpu_write(16'hFF00, 8'h00, 1'b0); chk("s3_go", 32'(Execute), 32'd1);

    // Asynchronous reset in the middle of the transfer
    #2 nRESET = 1'b0;
    #1;
    chk("async_exec", 32'(Execute), 32'd0);
    chk("async_ca", 32'(CA), 32'd0);
    model_reset();
    #1 nRESET = 1'b1;

    // Autoload with fixed CA
    cpu_write(16'hDF02, 8'h00, 1'b0); cpu_write(16'hDF03, 8'h20, 1'b0);
    cpu_write(16'hDF06, 8'h01, 1'b0);
    cpu_write(16'hDF07, 8'h02, 1'b0); cpu_write(16'hDF08, 8'h00, 1'b0);
    cpu_write(16'hDF0A, 8'h80, 1'b0);
    cpu_write(16'hDF01, 8'hB0, 1'b0);
    repeat (2) strobe(1'b1, 1'b1, 1'b0, 1'b0);
    chk("s4_reua_step", 32'(REUA), 32'h010002);
    strobe(1'b0, 1'b0, 1'b1, 1'b0);
    chk("s4_ca", 32'(CA), 32'h2000);
    chk("s4_reua", 32'(REUA), 32'h010000);
    cpu_read(16'hDF07, 1'b0, rd); chk("s4_len_lo", 32'(rd), 32'h02);
    cpu_read(16'hDF08, 1'b0, rd); chk("s4_len_hi", 32'(rd), 32'h00);

    // Verify fault interrupt and its release by a STATUS read
    cpu_read(16'hDF00, 1'b0, rd);
    cpu_write(16'hDF0A, 8'h00, 1'b0);
    cpu_write(16'hDF09, 8'hE0, 1'b0);
    cpu_write(16'hDF01, 8'h90, 1'b0);
    strobe(1'b0, 1'b0, 1'b1, 1'b1);
    chk("s5_nirq_low", 32'(nIRQ), 32'd0);
    cpu_read(16'hDF00, 1'b0, rd); chk("s5_status", 32'(rd), 32'hB0);
    chk("s5_nirq_rel", 32'(nIRQ), 32'd1);
    cpu_read(16'hDF00, 1'b0, rd); chk("s5_status2", 32'(rd), 32'h10);

    // Length 0 wrap and REUA wrap at 2^REUA_BITS
    cpu_write(16'hDF07, 8'h00, 1'b0); cpu_write(16'hDF08, 8'h00, 1'b0);
    strobe(1'b1, 1'b0, 1'b0, 1'b0);
    cpu_read(16'hDF07, 1'b0, rd); chk("s6_len_lo", 32'(rd), 32'hFF);
    cpu_read(16'hDF08, 1'b0, rd); chk("s6_len_hi", 32'(rd), 32'hFF);
    cpu_write(16'hDF04, 8'hFF, 1'b0); cpu_write(16'hDF05, 8'hFF, 1'b0);
    cpu_write(16'hDF06, 8'h07, 1'b0);
    strobe(1'b0, 1'b1, 1'b0, 1'b0);
    chk("s6_reua_wrap", 32'(REUA), 32'h000000);

    // Synchronous clear from the sequencer
    cpu_write(16'hDF02, 8'h55, 1'b0);
    RegReset = 1'b1;
    $display("seq  regreset");
    edge_step();
    chk("regreset_ca", 32'(CA), 32'd0);

    // Randomized traffic
    for (int n = 0; n < 800; n++) begin
      int op;
      op = $urandom_range(0, 99);
      if (op < 35)
        cpu_write(16'hDF00 | 16'($urandom_range(0, ($urandom_range(0, 3) == 0) ? 31 : 10)),
                  8'($urandom), 1'($urandom_range(0, 9) == 0));
      else if (op < 55)
        cpu_read(16'hDF00 | 16'($urandom_range(0, 12)), 1'($urandom_range(0, 9) == 0), rd);
      else if (op < 60)
        cpu_write(($urandom_range(0, 1) == 0) ? 16'hFF00 : 16'hFF01, 8'($urandom),
                  1'($urandom_range(0, 5) == 0));
      else if (op < 99)
        strobe(1'($urandom), 1'($urandom), 1'($urandom_range(0, 7) == 0), 1'($urandom));
      else begin
        RegReset = 1'b1;
        $display("seq  regreset");
        edge_step();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
